// File: rtl/sum_burst_accumulator.sv
// sum_burst_accumulator
//  Captures each {s8_cout,s8_sum} adder result as a 9-bit unsigned sample.
//  Accumulates BURST_LEN samples into an ACC_W-bit total.
//  Presents the total, the number of carry events and a sticky overflow flag
//  on a valid/ready output port.
//  Optional feature macro: SUM_ACC_SAT_EN. When it is defined, the
//  accumulator saturates at all-ones instead of wrapping.
module sum_burst_accumulator #(
   parameter int ACC_W     = 16,
   parameter int BURST_LEN = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clear,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [7:0]       s8_sum,
   input  logic             s8_cout,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [ACC_W-1:0] acc_out,
   output logic [7:0]       carry_cnt,
   output logic             ovf
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      DONE  = 2'd2
   } state_t;

   // Index of the sample that completes a burst.
   localparam logic [7:0] LAST_IDX = 8'(BURST_LEN - 1);

   state_t           state_q, state_d;
   logic [ACC_W-1:0] acc_q, acc_d;
   logic [7:0]       count_q, count_d;
   logic [7:0]       carry_cnt_q, carry_cnt_d;
   logic             ovf_q, ovf_d;
   logic             out_valid_q, out_valid_d;

   logic [ACC_W-1:0] sample;
   logic [ACC_W:0]   sum_full;
   logic             add_carry;
   logic [ACC_W-1:0] acc_add;
   logic             accept;

   // Add path: widen the sample, add with one spare bit to catch the carry out of ACC_W.
   always_comb begin
      sample    = ACC_W'({s8_cout, s8_sum});
      sum_full  = {1'b0, acc_q} + {1'b0, sample};
      add_carry = sum_full[ACC_W];
`ifdef SUM_ACC_SAT_EN
      acc_add   = add_carry ? {ACC_W{1'b1}} : sum_full[ACC_W-1:0];
`else
      acc_add   = sum_full[ACC_W-1:0];
`endif
   end

   // Handshake: the block stays closed while a result is held or reset is asserted.
   always_comb begin
      in_ready = (state_q != DONE) & ~rst;
      accept   = in_valid & in_ready & ~clear;
   end

   // Next-state logic: clear wins; otherwise accumulate in IDLE/ACCUM, hand off in DONE.
   always_comb begin
      state_d     = state_q;
      acc_d       = acc_q;
      count_d     = count_q;
      carry_cnt_d = carry_cnt_q;
      ovf_d       = ovf_q;
      out_valid_d = out_valid_q;

      if (clear) begin
         state_d     = IDLE;
         acc_d       = '0;
         count_d     = '0;
         carry_cnt_d = '0;
         ovf_d       = 1'b0;
         out_valid_d = 1'b0;
      end else begin
         case (state_q)
            IDLE, ACCUM: begin
               if (accept) begin
                  acc_d       = acc_add;
                  count_d     = count_q + 8'd1;
                  carry_cnt_d = carry_cnt_q + {7'd0, s8_cout};
                  ovf_d       = ovf_q | add_carry;
                  if (count_q == LAST_IDX) begin
                     state_d     = DONE;
                     out_valid_d = 1'b1;
                  end else begin
                     state_d = ACCUM;
                  end
               end
            end
            DONE: begin
               if (out_ready) begin
                  state_d     = IDLE;
                  acc_d       = '0;
                  count_d     = '0;
                  carry_cnt_d = '0;
                  ovf_d       = 1'b0;
                  out_valid_d = 1'b0;
               end
            end
            default: begin
               state_d     = IDLE;
               out_valid_d = 1'b0;
            end
         endcase
      end
   end

   // State registers with synchronous reset back to an empty IDLE burst.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         acc_q       <= '0;
         count_q     <= '0;
         carry_cnt_q <= '0;
         ovf_q       <= 1'b0;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         acc_q       <= acc_d;
         count_q     <= count_d;
         carry_cnt_q <= carry_cnt_d;
         ovf_q       <= ovf_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign out_valid = out_valid_q;
   assign acc_out   = acc_q;
   assign carry_cnt = carry_cnt_q;
   assign ovf       = ovf_q;

endmodule

// File: tb/tb_sum_burst_accumulator.sv
// tb_sum_burst_accumulator
//  Main instance: defaults (ACC_W=16, BURST_LEN=4), checked each cycle against a
//  sample-queue model of the burst.
//  Second instance: ACC_W=9, BURST_LEN=2, used for overflow cases.
//  The overflow expectation follows SUM_ACC_SAT_EN.
module tb_sum_burst_accumulator;

   localparam int BL = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        clear = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [7:0]  s8_sum = '0;
   logic        s8_cout = 1'b0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [15:0] acc_out;
   logic [7:0]  carry_cnt;
   logic        ovf;

   logic        o_clear = 1'b0;
   logic        o_in_valid = 1'b0;
   logic        o_in_ready;
   logic [7:0]  o_s8_sum = '0;
   logic        o_s8_cout = 1'b0;
   logic        o_out_valid;
   logic        o_out_ready = 1'b0;
   logic [8:0]  o_acc_out;
   logic [7:0]  o_carry_cnt;
   logic        o_ovf;

   int checks = 0;
   int errors = 0;

   // Samples absorbed into the current burst of the main instance.
   logic [8:0] q[$];

   sum_burst_accumulator #(.ACC_W(16), .BURST_LEN(BL)) dut (
      .clk(clk), .rst(rst), .clear(clear),
      .in_valid(in_valid), .in_ready(in_ready),
      .s8_sum(s8_sum), .s8_cout(s8_cout),
      .out_valid(out_valid), .out_ready(out_ready),
      .acc_out(acc_out), .carry_cnt(carry_cnt), .ovf(ovf)
   );

   sum_burst_accumulator #(.ACC_W(9), .BURST_LEN(2)) dut_ovf (
      .clk(clk), .rst(rst), .clear(o_clear),
      .in_valid(o_in_valid), .in_ready(o_in_ready),
      .s8_sum(o_s8_sum), .s8_cout(o_s8_cout),
      .out_valid(o_out_valid), .out_ready(o_out_ready),
      .acc_out(o_acc_out), .carry_cnt(o_carry_cnt), .ovf(o_ovf)
   );

   // Free-running clock.
   always #5 clk = ~clk;

   // Expected accumulator from the plain sum of the burst: wrap, or pin at all-ones once exceeded.
   function automatic logic [31:0] modelAcc(input int w, input int total);
      logic [31:0] lim;
      lim = (32'd1 << w) - 32'd1;
      if (total > int'(lim)) begin
`ifdef SUM_ACC_SAT_EN
         return lim;
`else
         return 32'(total) & lim;
`endif
      end
      return 32'(total);
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic checkValue(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Compare every main-instance output against the queue model.
   task automatic checkOutput(input string tag);
      int total;
      int cc;
      logic done;
      total = 0;
      cc = 0;
      foreach (q[i]) begin
         total += int'(q[i]);
         cc += int'(q[i][8]);
      end
      done = (q.size() == BL);
      checkValue({tag, ".out_valid"}, 32'(out_valid), 32'(done));
      checkValue({tag, ".in_ready"}, 32'(in_ready), 32'(!done && !rst));
      checkValue({tag, ".acc_out"}, 32'(acc_out), modelAcc(16, total));
      checkValue({tag, ".carry_cnt"}, 32'(carry_cnt), 32'(cc));
      checkValue({tag, ".ovf"}, 32'(ovf), 32'(total > 65535));
   endtask

   // Drive one cycle on the main instance, advance the model, then check.
   task automatic applyStimulus(input string tag, input logic v, input logic [8:0] smp,
                                input logic rdy, input logic clr);
      logic done;
      in_valid  = v;
      s8_cout   = smp[8];
      s8_sum    = smp[7:0];
      out_ready = rdy;
      clear     = clr;
      done      = (q.size() == BL);
      tick();
      if (clr) q.delete();
      else if (done && rdy) q.delete();
      else if (!done && v) q.push_back(smp);
      checkOutput(tag);
   endtask

   task automatic driveOvf(input logic v, input logic [8:0] smp, input logic rdy);
      o_in_valid  = v;
      o_s8_cout   = smp[8];
      o_s8_sum    = smp[7:0];
      o_out_ready = rdy;
      tick();
   endtask

   // Directed scenarios followed by a randomized run, all in one linear sequence.
   initial begin
      logic [8:0] s1 [4];
      logic [8:0] s2 [4];
      logic [31:0] sat_exp;

      // Reset: outputs zero, in_ready low while rst is high, high once it drops.
      rst = 1'b1;
      tick();
      tick();
      checkOutput("reset");
      checkValue("reset.o_out_valid", 32'(o_out_valid), 32'd0);
      checkValue("reset.o_in_ready", 32'(o_in_ready), 32'd0);
      rst = 1'b0;
      #1;
      checkValue("reset.in_ready_after", 32'(in_ready), 32'd1);

      // Overflow on the 9-bit instance.
`ifdef SUM_ACC_SAT_EN
      sat_exp = 32'h1FF;
`else
      sat_exp = 32'h001;
`endif
      driveOvf(1'b1, 9'h1FF, 1'b0);
      checkValue("ovf.first_acc", 32'(o_acc_out), 32'h1FF);
      checkValue("ovf.first_flag", 32'(o_ovf), 32'd0);
      driveOvf(1'b1, 9'h002, 1'b0);
      checkValue("ovf.done_valid", 32'(o_out_valid), 32'd1);
      checkValue("ovf.done_acc", 32'(o_acc_out), sat_exp);
      checkValue("ovf.done_flag", 32'(o_ovf), 32'd1);
      checkValue("ovf.done_carry", 32'(o_carry_cnt), 32'd1);
      driveOvf(1'b0, 9'h000, 1'b1);
      checkValue("ovf.handoff_valid", 32'(o_out_valid), 32'd0);
      checkValue("ovf.handoff_flag", 32'(o_ovf), 32'd0);
      driveOvf(1'b1, 9'h001, 1'b0);
      driveOvf(1'b1, 9'h002, 1'b0);
      checkValue("ovf.clean_acc", 32'(o_acc_out), 32'd3);
      checkValue("ovf.clean_flag", 32'(o_ovf), 32'd0);
      driveOvf(1'b0, 9'h000, 1'b1);

      // Nominal burst.
      s1 = '{9'h01E, 9'h00F, 9'h010, 9'h014};
      for (int i = 0; i < 4; i++) applyStimulus("nominal", 1'b1, s1[i], 1'b1, 1'b0);
      checkValue("nominal.total", 32'(acc_out), 32'd81);
      applyStimulus("nominal.handoff", 1'b0, 9'h000, 1'b1, 1'b0);

      // Carry events.
      s2 = '{9'h12C, 9'h003, 9'h100, 9'h001};
      for (int i = 0; i < 4; i++) applyStimulus("carry", 1'b1, s2[i], 1'b0, 1'b0);
      checkValue("carry.total", 32'(acc_out), 32'd560);
      checkValue("carry.count", 32'(carry_cnt), 32'd2);

      // Backpressure: result held, inputs ignored for 5 cycles.
      for (int i = 0; i < 5; i++)
         applyStimulus("backpressure", 1'b1, 9'($urandom_range(0, 511)), 1'b0, 1'b0);
      checkValue("backpressure.total", 32'(acc_out), 32'd560);
      applyStimulus("backpressure.handoff", 1'b1, 9'h055, 1'b1, 1'b0);
      applyStimulus("backpressure.fresh", 1'b1, 9'h007, 1'b0, 1'b0);
      checkValue("backpressure.fresh_acc", 32'(acc_out), 32'd7);
      applyStimulus("pre_clear", 1'b0, 9'h000, 1'b0, 1'b1);

      // Clear mid-burst with a coincident sample.
      applyStimulus("clear.pre", 1'b1, 9'h00A, 1'b0, 1'b0);
      applyStimulus("clear.pre", 1'b1, 9'h00A, 1'b0, 1'b0);
      applyStimulus("clear.pulse", 1'b1, 9'h107, 1'b0, 1'b1);
      for (int i = 0; i < 4; i++) applyStimulus("clear.post", 1'b1, 9'h005, 1'b0, 1'b0);
      checkValue("clear.total", 32'(acc_out), 32'd20);
      checkValue("clear.carry", 32'(carry_cnt), 32'd0);

      // Reset while a result is held.
      rst = 1'b1;
      tick();
      q.delete();
      checkOutput("rst_done");
      rst = 1'b0;
      #1;
      checkValue("rst_done.in_ready_after", 32'(in_ready), 32'd1);

      // Randomized traffic against the queue model.
      for (int i = 0; i < 400; i++) begin
         applyStimulus("random",
                       1'($urandom_range(0, 3) != 0),
                       9'($urandom_range(0, 511)),
                       1'($urandom_range(0, 2) == 0),
                       1'($urandom_range(0, 40) == 0));
      end

      $display("[TB] directed and random sequences complete");
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
